// File: rtl/alu_cmd_sequencer.sv
// Byte-serial command sequencer for the combinational ALU: collects operand A,
// operand B and opcode, runs one settling cycle, then hands the result to a transmitter.
module alu_cmd_sequencer #(
    parameter int N_BITS         = 8,
    parameter int OP_BITS        = 6,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_BITS-1:0]  rx_data,
    input  logic               rx_valid,
    input  logic               tx_ready,
    output logic               tx_start,
    output logic [N_BITS-1:0]  tx_data,
    output logic [N_BITS-1:0]  alu_d0,
    output logic [N_BITS-1:0]  alu_d1,
    output logic [OP_BITS-1:0] alu_opcode,
    input  logic [N_BITS-1:0]  alu_result,
    output logic               busy,
    output logic               timeout_err,
    output logic               overrun
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WAIT_B  = 3'd1;
    localparam logic [2:0] WAIT_OP = 3'd2;
    localparam logic [2:0] EXEC    = 3'd3;
    localparam logic [2:0] SEND    = 3'd4;

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N_BITS-1:0]  d0_q, d0_d, d1_q, d1_d, txData_q, txData_d;
    logic [OP_BITS-1:0] op_q, op_d;
    logic               txStart_q, txStart_d;
    logic               timeout_q, timeout_d;
    logic               overrun_q, overrun_d;

    // A byte arriving on the expiry edge is accepted, so rx_valid is tested before the count.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        d0_d      = d0_q;
        d1_d      = d1_q;
        op_d      = op_q;
        txData_d  = txData_q;
        txStart_d = 1'b0;
        timeout_d = 1'b0;
        overrun_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (rx_valid) begin
                    d0_d    = rx_data;
                    cnt_d   = '0;
                    state_d = WAIT_B;
                end
            end
            WAIT_B, WAIT_OP: begin
                if (rx_valid) begin
                    cnt_d = '0;
                    if (state_q == WAIT_B) begin
                        d1_d    = rx_data;
                        state_d = WAIT_OP;
                    end else begin
                        op_d    = rx_data[OP_BITS-1:0];
                        state_d = EXEC;
                    end
                end else if (cnt_q == CNT_MAX) begin
                    cnt_d     = '0;
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            EXEC: begin
                txData_d  = alu_result;
                overrun_d = rx_valid;
                state_d   = SEND;
            end
            SEND: begin
                overrun_d = rx_valid;
                if (tx_ready) begin
                    txStart_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            d0_q      <= '0;
            d1_q      <= '0;
            op_q      <= '0;
            txData_q  <= '0;
            txStart_q <= 1'b0;
            timeout_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            d0_q      <= d0_d;
            d1_q      <= d1_d;
            op_q      <= op_d;
            txData_q  <= txData_d;
            txStart_q <= txStart_d;
            timeout_q <= timeout_d;
            overrun_q <= overrun_d;
        end
    end

    assign tx_start    = txStart_q;
    assign tx_data     = txData_q;
    assign alu_d0      = d0_q;
    assign alu_d1      = d1_q;
    assign alu_opcode  = op_q;
    assign busy        = (state_q != IDLE);
    assign timeout_err = timeout_q;
    assign overrun     = overrun_q;

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Sequences the combinational ALU from a byte-serial command stream, such as a UART receiver.
- Collects three bytes in order: operand A, operand B, opcode. Drives them onto the ALU inputs, captures the result and hands it to a transmitter with a start/ready handshake.
- Sits between the UART rx/tx blocks and the ALU; an inter-byte timeout recovers from partial commands.

Parameters:
- N_BITS, 8, data/operand width; must be >= 6.
- OP_BITS, 6, opcode width; opcode taken from rx_data[OP_BITS-1:0].
- TIMEOUT_CYCLES, 1024, idle cycles allowed between bytes of one command before abort; >= 2.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- rx_data  input  N_BITS  received byte; valid only while rx_valid is high.
- rx_valid  input  1  single-cycle strobe, one per received byte.
- tx_ready  input  1  transmitter idle; can accept tx_start.
- tx_start  output  1  single-cycle request to send tx_data.
- tx_data  output  N_BITS  captured ALU result.
- alu_d0  output  N_BITS  ALU operand A.
- alu_d1  output  N_BITS  ALU operand B.
- alu_opcode  output  OP_BITS  ALU opcode.
- alu_result  input  N_BITS  combinational ALU output.
- busy  output  1  high whenever state != IDLE.
- timeout_err  output  1  one-cycle pulse on inter-byte timeout.
- overrun  output  1  one-cycle pulse when a byte is dropped.

Behaviour:
- Reset:
  - Asynchronous: state IDLE; all outputs and internal registers 0.
  - Reset asserted mid-command takes effect immediately; tx_start deasserts without waiting for a clock edge.
- State machine, all transitions on the rising clk edge:
  - IDLE: on rx_valid, alu_d0 <= rx_data, go to WAIT_B.
  - WAIT_B: on rx_valid, alu_d1 <= rx_data, go to WAIT_OP.
  - WAIT_OP: on rx_valid, alu_opcode <= rx_data[OP_BITS-1:0], go to EXEC.
  - EXEC: exactly one cycle for ALU settling; tx_data <= alu_result, go to SEND.
  - SEND: when tx_ready is sampled high, tx_start <= 1 and go to IDLE. With tx_ready low, stay in SEND indefinitely; no timeout applies.
- tx_start is registered: high for exactly one cycle, the first cycle back in IDLE; otherwise 0.
- Latency:
  - Opcode byte accepted at edge E0 → tx_data valid after E0+1.
  - With tx_ready high, tx_start is high in the cycle after E0+2 (minimum 2 edges).
- Register hold rules:
  - alu_d0, alu_d1 and alu_opcode hold their values until overwritten by a new byte or reset; timeout does not clear them.
  - tx_data holds until the next EXEC.
- Timeout:
  - Counter is active only in WAIT_B and WAIT_OP. It clears on entry and on every accepted byte, and increments each cycle without rx_valid.
  - When the count reaches TIMEOUT_CYCLES-1 without rx_valid: go to IDLE and pulse timeout_err for one cycle.
  - rx_valid on the expiry edge: the byte wins; it is accepted normally and no error is raised.
- Overrun: rx_valid while in EXEC or SEND drops the byte, pulses overrun for one cycle, and leaves state unchanged.
- Arithmetic: none in this block. Upper rx_data bits above OP_BITS are ignored for the opcode byte.
- Implicit rx_valid rule: rx_valid held high for k cycles counts as k bytes.

Test Plan:
1. ADD, normal path: TIMEOUT_CYCLES=16, tx_ready=1. Send 0x05, 0x03, 0x20 (one strobe each, gaps of 3 cycles). Required: alu_d0=0x05, alu_d1=0x03, alu_opcode=0x20, tx_data=0x08; tx_start one cycle, 2 edges after the opcode is accepted; busy returns to 0.
2. SUB wrap and NOR: send 0x03, 0x05, 0x22 → tx_data=0xFE. Then send 0x0F, 0xF0, 0x27 → tx_data=0x00. Exactly one tx_start per command.
3. Backpressure: hold tx_ready=0 for 10 cycles after EXEC. Required: tx_start stays 0, state remains SEND, busy=1. Raise tx_ready → tx_start is a single pulse on the following cycle.
4. Timeout: send only 0x11, then idle 16 cycles. Required: timeout_err pulses once, state IDLE, alu_d0 still 0x11. Then send 0x02, 0x02, 0x20 → tx_data=0x04.
5. Overrun and simultaneity:
   - Strobe rx_valid=0x77 during SEND (tx_ready=0) → overrun pulses, byte not taken as operand A.
   - Separately, deliver a byte exactly on the timeout-expiry edge → accepted, no timeout_err.
6. Reset mid-command: after 0xAA, 0xBB, assert reset asynchronously between edges. Required: all outputs 0 immediately. After release, a fresh 0x01, 0x01, 0x24 → tx_data=0x01.
